// File: rtl/ladybird_fetch.sv
// ladybird_fetch -- instruction fetch stage.
// Issues sequential word-aligned fetch addresses to the memory unit under a
// credit limit, buffers returned words in a DEPTH-entry prefetch FIFO and
// presents them to decode. A redirect flushes the FIFO, marks all in-flight
// responses for discard and restarts fetch at the new target.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   pc, pc_valid, pc_ready      fetch request to memory unit
//   inst, inst_pc, inst_valid,
//   inst_ready                  returned instruction word (always accepted)
//   redirect_valid, redirect_pc control-flow redirect pulse and target
//   fetch_inst, fetch_pc,
//   fetch_valid, fetch_ready    FIFO head presented to decode
module ladybird_fetch #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     DEPTH        = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] inst_pc,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fetch_inst,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW:0] credit_used;
  logic        req_fire, rsp_fire, drop_hit, push, pop, wr_en;

  // Every accepted request reserves a FIFO slot, so responses never need
  // back-pressure.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
  assign pc_valid    = credit_used < DEPTH_C;
  assign pc          = next_pc_q;
  assign inst_ready  = 1'b1;

  assign fetch_valid = count_q != '0;
  assign fetch_inst  = fetch_valid ? inst_mem[rd_ptr_q] : '0;
  assign fetch_pc    = fetch_valid ? pc_mem[rd_ptr_q]   : '0;

  assign req_fire = pc_valid & pc_ready;
  assign rsp_fire = inst_valid;
  assign drop_hit = rsp_fire & (drop_q != '0);
  assign push     = rsp_fire & ~drop_hit;
  assign pop      = fetch_valid & fetch_ready;
  assign wr_en    = push & ~redirect_valid;

  always_comb begin
    next_pc_d = next_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    drop_d    = drop_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(rsp_fire);

    if (req_fire) begin
      next_pc_d = next_pc_q + XLEN'(4);
    end

    if (redirect_valid) begin
      // Everything still in flight after this cycle's events is stale,
      // including a request accepted right now.
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      drop_d    = outst_d;
      next_pc_d = redirect_pc & ALIGN_MASK;
    end else begin
      if (drop_hit) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc_q <= RESET_VECTOR & ALIGN_MASK;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      next_pc_q <= next_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wr_ptr_q] <= inst;
      pc_mem[wr_ptr_q]   <= inst_pc;
    end
  end

endmodule

// File: tb/tb_ladybird_fetch.sv
module tb_ladybird_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;

  ladybird_fetch #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_valid(pc_valid),
    .pc_ready(pc_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // Memory model controls (written by the stimulus process only).
  int budget   = 0;
  int mem_lat  = 2;
  int hs_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    e.pc   = a;
    e.inst = w;
    sb.push_back(e);
  endtask

  task automatic drain(input int maxc, input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < maxc) begin
      tick(1);
      n++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL %s: %0d expected words never delivered within %0d cycles", name, sb.size(), maxc);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    budget      = 0;
    fetch_ready = 1'b0;
    tick(2);
    sb.delete();
    hs_count = 0;
    rst      = 1'b0;
  endtask

  // Memory unit model: in-order, accepts while budget remains, returns
  // inst = addr ^ A5A5_0000 mem_lat cycles after the request handshake.
  initial begin
    req_t mq[$];
    req_t r;
    int   cyc;
    cyc        = 0;
    pc_ready   = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        mq.delete();
        inst_valid = 1'b0;
        pc_ready   = 1'b0;
      end else begin
        inst_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          r          = mq.pop_front();
          inst       = r.addr ^ 32'hA5A5_0000;
          inst_pc    = r.addr;
          inst_valid = 1'b1;
        end
        pc_ready = budget > 0;
        if (pc_valid && pc_ready) begin
          r.addr = pc;
          r.due  = cyc + mem_lat;
          mq.push_back(r);
          budget--;
          hs_count++;
        end
      end
    end
  end

  // Scoreboard monitor: compares every word decode consumes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && fetch_valid && fetch_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got pc %h inst %h, expected no word", fetch_pc, fetch_inst);
        end else begin
          e = sb.pop_front();
          check("sb_pc", fetch_pc, e.pc);
          check("sb_inst", fetch_inst, e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick(2);

    // Reset values.
    check("rst_pc", pc, 32'h0);
    check("rst_pc_valid", {31'b0, pc_valid}, 32'h1);
    check("rst_inst_ready", {31'b0, inst_ready}, 32'h1);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_fetch_inst", fetch_inst, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);

    // Sequential fetch with memory latency 2.
    do_reset();
    mem_lat     = 2;
    budget      = 4;
    fetch_ready = 1'b1;
    expect_word(32'h0000_0000, 32'hA5A5_0000);
    expect_word(32'h0000_0004, 32'hA5A5_0004);
    expect_word(32'h0000_0008, 32'hA5A5_0008);
    expect_word(32'h0000_000C, 32'hA5A5_000C);
    drain(10, "seq_drain");

    // Decode stalled: credit limits requests to DEPTH.
    do_reset();
    mem_lat = 2;
    budget  = 100;
    tick(20);
    check("stall_req_count", hs_count, 32'd4);
    check("stall_pc_valid", {31'b0, pc_valid}, 32'h0);
    check("stall_next_pc", pc, 32'h0000_0010);
    check("stall_fetch_valid", {31'b0, fetch_valid}, 32'h1);
    budget      = 2;
    fetch_ready = 1'b1;
    expect_word(32'h0000_0000, 32'hA5A5_0000);
    expect_word(32'h0000_0004, 32'hA5A5_0004);
    expect_word(32'h0000_0008, 32'hA5A5_0008);
    expect_word(32'h0000_000C, 32'hA5A5_000C);
    expect_word(32'h0000_0010, 32'hA5A5_0010);
    expect_word(32'h0000_0014, 32'hA5A5_0014);
    drain(15, "stall_drain");

    // Redirect with 2 buffered and 1 outstanding.
    do_reset();
    mem_lat = 2;
    budget  = 2;
    tick(8);
    check("redir_pre_head_pc", fetch_pc, 32'h0000_0000);
    check("redir_pre_head_inst", fetch_inst, 32'hA5A5_0000);
    mem_lat = 10;
    budget  = 1;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick(1);
    redirect_valid = 1'b0;
    check("redir_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("redir_pc", pc, 32'h8000_0100);
    check("redir_pc_valid", {31'b0, pc_valid}, 32'h1);
    mem_lat     = 2;
    budget      = 1;
    fetch_ready = 1'b1;
    expect_word(32'h8000_0100, 32'h25A5_0100);
    drain(30, "redir_drain");
    tick(4);

    // Redirect coinciding with a request and a response handshake.
    do_reset();
    mem_lat = 1;
    budget  = 2;
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick(1);
    redirect_valid = 1'b0;
    check("same_cyc_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("same_cyc_pc", pc, 32'h0000_0040);
    check("same_cyc_req_accepted", hs_count, 32'd2);
    budget      = 1;
    fetch_ready = 1'b1;
    expect_word(32'h0000_0040, 32'hA5A5_0040);
    drain(10, "same_cyc_drain");
    tick(4);

    // Address wrap after redirect to the last word.
    do_reset();
    mem_lat        = 2;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    budget = 2;
    expect_word(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    expect_word(32'h0000_0000, 32'hA5A5_0000);
    drain(12, "wrap_drain");

    // Asynchronous reset with a full FIFO.
    do_reset();
    mem_lat = 2;
    budget  = 100;
    tick(15);
    check("full_pc_valid", {31'b0, pc_valid}, 32'h0);
    check("full_fetch_valid", {31'b0, fetch_valid}, 32'h1);
    budget = 0;
    rst    = 1'b1;
    #2;
    check("midrst_pc", pc, 32'h0);
    check("midrst_pc_valid", {31'b0, pc_valid}, 32'h1);
    check("midrst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("midrst_fetch_inst", fetch_inst, 32'h0);
    check("midrst_fetch_pc", fetch_pc, 32'h0);
    tick(1);
    sb.delete();
    rst         = 1'b0;
    budget      = 1;
    fetch_ready = 1'b1;
    expect_word(32'h0000_0000, 32'hA5A5_0000);
    drain(10, "midrst_drain");
    tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
